count_updown_n: RTL and testbench

Parametrised up/down counter; next generation of the 4-bit CTL-controlled counter. Adds:
- configurable width and modulus
- synchronous parallel load
- count enable
- wrap or saturate selection
- terminal-count and wrap-event flags for cascading and timer use

Sits in the datapath as a general event/timer counter. Instances can be chained through tc.

---
 rtl/count_pkg.sv | 10 +
 rtl/count_next.sv | 36 +++
 rtl/count_updown_n.sv | 45 ++++
 tb/tb_count_updown_n.sv | 110 +++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared direction/mode constants and parameter legality check for the up/down counter
package count_pkg;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  function automatic bit params_ok(input int unsigned width, input logic [31:0] max_val, input logic [31:0] reset_val);
    return width >= 2 && width <= 32 && max_val >= 1 && reset_val <= max_val;
  endfunction
endpackage

// File: rtl/count_next.sv
// count_next: combinational next-count and wrap-event logic for the up/down counter
module count_next
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] y_i,
  input  logic             en_i,
  input  logic             ctl_i,
  input  logic             sat_mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] y_o,
  output logic             wrap_o
);
  logic             at_max;
  logic             at_zero;
  logic             at_end;
  logic             sat;
  logic [WIDTH-1:0] up_y;
  logic [WIDTH-1:0] dn_y;
  logic [WIDTH-1:0] ld_y;
  // The +1/-1 steps are only selected away from the range ends, so they never leave WIDTH bits.
  always_comb begin
    at_max  = y_i == MAX_VAL;
    at_zero = y_i == '0;
    sat     = sat_mode_i == MODE_SAT;
    at_end  = ctl_i == DIR_DOWN ? at_zero : at_max;
    up_y    = at_max ? (sat ? y_i : '0) : y_i + WIDTH'(1);
    dn_y    = at_zero ? (sat ? y_i : MAX_VAL) : y_i - WIDTH'(1);
    ld_y    = load_val_i > MAX_VAL ? MAX_VAL : load_val_i;
    y_o     = load_i ? ld_y : en_i ? (ctl_i == DIR_DOWN ? dn_y : up_y) : y_i;
    wrap_o  = !load_i && en_i && at_end && sat_mode_i == MODE_WRAP;
  end
endmodule

// File: rtl/count_updown_n.sv
// count_updown_n: parametrised up/down counter with load, enable, wrap/saturate, tc and wrap flags
module count_updown_n
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             CTL,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] Y,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             wrap_q;
  logic             wrap_d;
  if (!params_ok(WIDTH, 32'(MAX_VAL), 32'(RESET_VAL))) begin : g_bad_params
    $error("count_updown_n: illegal WIDTH/MAX_VAL/RESET_VAL");
  end
  count_next #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_next (
    .y_i        (y_q),
    .en_i       (en),
    .ctl_i      (CTL),
    .sat_mode_i (sat_mode),
    .load_i     (load),
    .load_val_i (load_val),
    .y_o        (y_d),
    .wrap_o     (wrap_d)
  );
  // Count and wrap-pulse registers; reset overrides load and count.
  always_ff @(posedge clock) begin
    y_q    <= reset ? RESET_VAL : y_d;
    wrap_q <= reset ? 1'b0 : wrap_d;
  end
  assign Y    = y_q;
  assign wrap = wrap_q;
  assign tc   = en && (CTL == DIR_UP ? y_q == MAX_VAL : y_q == '0);
endmodule

// File: tb/tb_count_updown_n.sv
// tb_count_updown_n: table-driven and sequence checks of count_updown_n
module tb_count_updown_n;
  logic clock = 0;
  always #5 clock = ~clock;
  int checks = 0;
  int errors = 0;
  logic a_rst, a_en, a_ctl, a_ld, a_sat, a_tc, a_w;
  logic [3:0] a_lv, a_y;
  logic b_rst, b_en, b_ctl, b_ld, b_sat, b_tc, b_w;
  logic [3:0] b_lv, b_y;
  logic c_rst, lo_en, lo_tc, lo_w, hi_tc, hi_w;
  logic [3:0] lo_y, hi_y;
  count_updown_n #(.WIDTH(4), .MAX_VAL(4'd15), .RESET_VAL(4'd0)) dut_a (
    .clock(clock), .reset(a_rst), .en(a_en), .CTL(a_ctl), .load(a_ld), .load_val(a_lv),
    .sat_mode(a_sat), .Y(a_y), .tc(a_tc), .wrap(a_w));
  count_updown_n #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd0)) dut_b (
    .clock(clock), .reset(b_rst), .en(b_en), .CTL(b_ctl), .load(b_ld), .load_val(b_lv),
    .sat_mode(b_sat), .Y(b_y), .tc(b_tc), .wrap(b_w));
  count_updown_n #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd0)) dut_lo (
    .clock(clock), .reset(c_rst), .en(lo_en), .CTL(1'b0), .load(1'b0), .load_val(4'd0),
    .sat_mode(1'b0), .Y(lo_y), .tc(lo_tc), .wrap(lo_w));
  count_updown_n #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd0)) dut_hi (
    .clock(clock), .reset(c_rst), .en(lo_tc), .CTL(1'b0), .load(1'b0), .load_val(4'd0),
    .sat_mode(1'b0), .Y(hi_y), .tc(hi_tc), .wrap(hi_w));
  typedef struct {
    logic rst, en, ctl, ld, sat;
    logic [3:0] lv;
    logic tc;
    logic [3:0] y;
    logic w;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step_a(input logic rst, input logic en, input logic ctl, input logic exp_tc,
                        input logic [3:0] exp_y, input logic exp_w, input string name);
    a_rst = rst; a_en = en; a_ctl = ctl;
    #1 chk({name, " tc"}, 32'(a_tc), 32'(exp_tc));
    @(posedge clock); #1;
    chk({name, " Y"}, 32'(a_y), 32'(exp_y));
    chk({name, " wrap"}, 32'(a_w), 32'(exp_w));
  endtask
  initial begin
    a_rst = 1; a_en = 0; a_ctl = 0; a_ld = 0; a_sat = 0; a_lv = 0;
    b_rst = 1; b_en = 0; b_ctl = 0; b_ld = 0; b_sat = 0; b_lv = 0;
    c_rst = 1; lo_en = 0;
    //             rst en ctl ld sat lv     tc y     w
    tbl.push_back('{1, 1, 0, 0, 0, 4'd0,  0, 4'd0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 4'd0,  0, 4'd0, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 4'd12, 0, 4'd9, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd5,  0, 4'd5, 0});
    tbl.push_back('{0, 1, 1, 1, 0, 4'd3,  0, 4'd3, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd2,  0, 4'd2, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 4'd0,  0, 4'd1, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 4'd0,  0, 4'd0, 0});
    tbl.push_back('{0, 1, 1, 0, 0, 4'd0,  1, 4'd9, 1});
    tbl.push_back('{0, 1, 1, 0, 0, 4'd0,  0, 4'd8, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd8,  0, 4'd8, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 4'd0,  0, 4'd9, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 4'd0,  1, 4'd9, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 4'd0,  1, 4'd9, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 4'd1,  0, 4'd1, 0});
    tbl.push_back('{0, 1, 1, 0, 1, 4'd0,  0, 4'd0, 0});
    tbl.push_back('{0, 1, 1, 0, 1, 4'd0,  1, 4'd0, 0});
    tbl.push_back('{0, 1, 1, 0, 1, 4'd0,  1, 4'd0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd9,  0, 4'd9, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 4'd0,  1, 4'd0, 1});
    tbl.push_back('{0, 1, 0, 1, 0, 4'd4,  0, 4'd4, 0});
    tbl.push_back('{0, 1, 0, 1, 1, 4'd15, 0, 4'd9, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 4'd0,  1, 4'd0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 4'd0,  0, 4'd0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd7,  0, 4'd7, 0});
    tbl.push_back('{1, 1, 0, 1, 0, 4'd3,  0, 4'd0, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 4'd0,  0, 4'd1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 4'd9,  0, 4'd9, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 4'd0,  1, 4'd0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 4'd0,  0, 4'd0, 0});
    @(posedge clock); #1;
    foreach (tbl[i]) begin
      b_rst = tbl[i].rst; b_en = tbl[i].en; b_ctl = tbl[i].ctl;
      b_ld = tbl[i].ld; b_sat = tbl[i].sat; b_lv = tbl[i].lv;
      #1 chk($sformatf("vec%0d tc", i), 32'(b_tc), 32'(tbl[i].tc));
      @(posedge clock); #1;
      chk($sformatf("vec%0d Y", i), 32'(b_y), 32'(tbl[i].y));
      chk($sformatf("vec%0d wrap", i), 32'(b_w), 32'(tbl[i].w));
    end
    step_a(1, 0, 0, 0, 4'd0, 0, "a reset0");
    step_a(1, 0, 0, 0, 4'd0, 0, "a reset1");
    for (int i = 0; i < 16; i++)
      step_a(0, 1, 0, i == 15, 4'((i + 1) % 16), i == 15, $sformatf("a up%0d", i));
    step_a(0, 1, 1, 1, 4'd15, 1, "a down wrap");
    step_a(0, 1, 0, 1, 4'd0, 1, "a up wrap");
    step_a(0, 0, 0, 0, 4'd0, 0, "a hold");
    @(posedge clock); #1;
    c_rst = 0; lo_en = 1;
    for (int k = 1; k <= 101; k++) begin
      #1 chk($sformatf("casc%0d lo tc", k), 32'(lo_tc), 32'((k - 1) % 10 == 9));
      @(posedge clock); #1;
      chk($sformatf("casc%0d count", k), {24'd0, hi_y, lo_y}, 32'((((k / 10) % 10) << 4) | (k % 10)));
      chk($sformatf("casc%0d hi wrap", k), 32'(hi_w), 32'(k == 100));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
